// File: rtl/jt51_pg_acc.sv
// Time-multiplexed phase accumulator bank: one PW-bit phase per slot, stepped
// each time the slot comes round, with preset/hold and an output-only offset.
module jt51_pg_acc #(
  parameter int SLOTS = 32,
  parameter int PW    = 20,
  parameter int STEPW = 20,
  parameter int OW    = 10,
  parameter int CW    = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen_i,
  input  logic             zero_i,
  input  logic [STEPW-1:0] step_i,
  input  logic             pg_rst_i,
  input  logic             hold_i,
  input  logic [PW-1:0]    preset_i,
  input  logic [OW-1:0]    ofs_i,
  input  logic             err_clr_i,
  output logic [OW-1:0]    phase_out_o,
  output logic             wrap_o,
  output logic [CW-1:0]    slot_out_o,
  output logic             slot_err_o
);

  logic [SLOTS-1:0][PW-1:0] mem_q;
  logic [CW-1:0]            cnt_q, cnt_d, cur;
  logic [PW-1:0]            old_v, new_d;
  logic [PW:0]              sum;
  logic                     wrap_d;
  logic                     err_q, err_d;

  logic [OW-1:0]            topA_q, ofsA_q;
  logic                     wrapA_q;
  logic [CW-1:0]            slotA_q;

  logic [OW-1:0]            phase_q;
  logic                     wrap_q;
  logic [CW-1:0]            slot_q;

  // zero realigns the frame: the flagged input is always treated as slot 0
  always_comb begin
    cur    = zero_i ? '0 : cnt_q;
    cnt_d  = (cur == CW'(SLOTS-1)) ? '0 : cur + 1'b1;
    old_v  = mem_q[cur];
    sum    = {1'b0, old_v} + (PW+1)'(step_i);
    new_d  = sum[PW-1:0];
    wrap_d = sum[PW];
    if (pg_rst_i) begin
      new_d  = preset_i;
      wrap_d = 1'b0;
    end else if (hold_i) begin
      new_d  = old_v;
      wrap_d = 1'b0;
    end
    err_d = err_q;
    if (zero_i && cnt_q != '0) err_d = 1'b1;
    else if (err_clr_i)        err_d = 1'b0;
  end

  // A slot recurs only after SLOTS >= 2 cycles, so read and write never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      topA_q  <= '0;
      ofsA_q  <= '0;
      wrapA_q <= 1'b0;
      slotA_q <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      slot_q  <= '0;
    end else if (cen_i) begin
      mem_q[cur] <= new_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      topA_q     <= new_d[PW-1 -: OW];
      ofsA_q     <= ofs_i;
      wrapA_q    <= wrap_d;
      slotA_q    <= cur;
      phase_q    <= topA_q + ofsA_q;
      wrap_q     <= wrapA_q;
      slot_q     <= slotA_q;
    end
  end

  assign phase_out_o = phase_q;
  assign wrap_o      = wrap_q;
  assign slot_out_o  = slot_q;
  assign slot_err_o  = err_q;

endmodule

// File: tb/tb_jt51_pg_acc.sv
// Directed bench for jt51_pg_acc with SLOTS=4: each vector drives one slot
// cycle and checks the output of the previous cycle's slot.
module tb_jt51_pg_acc;
  localparam int SLOTS = 4;
  localparam int PW    = 20;
  localparam int STEPW = 20;
  localparam int OW    = 10;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cen = 1'b1;
  logic             zero = 1'b0;
  logic [STEPW-1:0] step = '0;
  logic             pg_rst = 1'b0;
  logic             hold = 1'b0;
  logic [PW-1:0]    preset = '0;
  logic [OW-1:0]    ofs = '0;
  logic             err_clr = 1'b0;
  logic [OW-1:0]    phase_out;
  logic             wrap;
  logic [CW-1:0]    slot_out;
  logic             slot_err;

  int n_chk = 0;
  int n_fail = 0;

  jt51_pg_acc #(.SLOTS(SLOTS), .PW(PW), .STEPW(STEPW), .OW(OW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cen_i(cen), .zero_i(zero), .step_i(step),
    .pg_rst_i(pg_rst), .hold_i(hold), .preset_i(preset), .ofs_i(ofs),
    .err_clr_i(err_clr), .phase_out_o(phase_out), .wrap_o(wrap),
    .slot_out_o(slot_out), .slot_err_o(slot_err)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one slot cycle, then check the outputs that appear after that edge.
  task automatic cyc(input logic z, input logic [STEPW-1:0] st, input logic [OW-1:0] eph,
                     input logic ew, input logic [CW-1:0] esl, input string tag);
    zero = z;
    step = st;
    @(posedge clk);
    #1;
    check1({tag, ".phase"}, 32'(phase_out), 32'(eph));
    check1({tag, ".wrap"},  32'(wrap),      32'(ew));
    check1({tag, ".slot"},  32'(slot_out),  32'(esl));
  endtask

  task automatic chk_err(input logic e, input string tag);
    check1({tag, ".err"}, 32'(slot_err), 32'(e));
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    chk_err(1'b0, "rst_hold");
    check1("rst_hold.phase", 32'(phase_out), 32'h0);
    rst_n = 1'b1;
    cyc(1'b1, 20'h10000, 10'h000, 1'b0, 2'd0, "pre_c0");
    cyc(1'b0, 20'h10000, 10'h040, 1'b0, 2'd0, "pre_s0");
    cyc(1'b0, 20'h10000, 10'h040, 1'b0, 2'd1, "pre_s1");
    cyc(1'b0, 20'h10000, 10'h040, 1'b0, 2'd2, "pre_s2");
    #2;
    rst_n = 1'b0;
    #1;
    check1("midrst.phase", 32'(phase_out), 32'h0);
    check1("midrst.wrap",  32'(wrap),      32'h0);
    check1("midrst.slot",  32'(slot_out),  32'h0);
    chk_err(1'b0, "midrst");
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd0, "post_c0");
    cyc(1'b0, 20'h0, 10'h000, 1'b0, 2'd0, "post_s0");
    cyc(1'b0, 20'h0, 10'h000, 1'b0, 2'd1, "post_s1");
    cyc(1'b0, 20'h0, 10'h000, 1'b0, 2'd2, "post_s2");

    // accumulate on slot 0
    cyc(1'b1, 20'h00400, 10'h000, 1'b0, 2'd3, "acc_f1_s3");
    cyc(1'b0, 20'h0,     10'h001, 1'b0, 2'd0, "acc_f1_s0");
    cyc(1'b0, 20'h0,     10'h000, 1'b0, 2'd1, "acc_f1_s1");
    cyc(1'b0, 20'h0,     10'h000, 1'b0, 2'd2, "acc_f1_s2");
    cyc(1'b1, 20'h00400, 10'h000, 1'b0, 2'd3, "acc_f2_s3");
    cyc(1'b0, 20'h0,     10'h002, 1'b0, 2'd0, "acc_f2_s0");
    cyc(1'b0, 20'h0,     10'h000, 1'b0, 2'd1, "acc_f2_s1");
    cyc(1'b0, 20'h0,     10'h000, 1'b0, 2'd2, "acc_f2_s2");
    // third frame: slot 0 reaches 3, slot 1 starts half-range steps
    cyc(1'b1, 20'h00400, 10'h000, 1'b0, 2'd3, "acc_f3_s3");
    cyc(1'b0, 20'h80000, 10'h003, 1'b0, 2'd0, "acc_f3_s0");
    cyc(1'b0, 20'h0,     10'h200, 1'b0, 2'd1, "wrap_f1_s1");
    cyc(1'b0, 20'h0,     10'h000, 1'b0, 2'd2, "wrap_f1_s2");
    cyc(1'b1, 20'h0,     10'h000, 1'b0, 2'd3, "wrap_f2_s3");
    cyc(1'b0, 20'h80000, 10'h003, 1'b0, 2'd0, "wrap_f2_s0");
    cyc(1'b0, 20'h0,     10'h000, 1'b1, 2'd1, "wrap_f2_s1");
    cyc(1'b0, 20'h0,     10'h000, 1'b0, 2'd2, "wrap_f2_s2");
    cyc(1'b1, 20'h0,     10'h000, 1'b0, 2'd3, "wrap_f3_s3");
    cyc(1'b0, 20'h80000, 10'h003, 1'b0, 2'd0, "wrap_f3_s0");
    cyc(1'b0, 20'h0,     10'h200, 1'b0, 2'd1, "wrap_f3_s1");
    cyc(1'b0, 20'h0,     10'h000, 1'b0, 2'd2, "wrap_f3_s2");

    // preset / hold / offset on slot 2
    preset = 20'h12345;
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "pre_f1_s3");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "pre_f1_s0");
    pg_rst = 1'b1;
    cyc(1'b0, 20'h0, 10'h200, 1'b0, 2'd1, "pre_f1_s1");
    pg_rst = 1'b0;
    cyc(1'b0, 20'h0, 10'h048, 1'b0, 2'd2, "preset");
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "pre_f2_s3");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "pre_f2_s0");
    pg_rst = 1'b1;
    hold = 1'b1;
    cyc(1'b0, 20'h00400, 10'h200, 1'b0, 2'd1, "pre_f2_s1");
    pg_rst = 1'b0;
    hold = 1'b0;
    cyc(1'b0, 20'h0, 10'h048, 1'b0, 2'd2, "preset_hold");
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "hold_s3");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "hold_s0");
    hold = 1'b1;
    cyc(1'b0, 20'h00400, 10'h200, 1'b0, 2'd1, "hold_s1");
    hold = 1'b0;
    cyc(1'b0, 20'h0, 10'h048, 1'b0, 2'd2, "hold");
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "ofs_s3");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "ofs_s0");
    ofs = 10'h3C0;
    cyc(1'b0, 20'h0, 10'h200, 1'b0, 2'd1, "ofs_s1");
    ofs = 10'h000;
    cyc(1'b0, 20'h0, 10'h008, 1'b0, 2'd2, "ofs_mod");
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "ofs2_s3");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "ofs2_s0");
    cyc(1'b0, 20'h0, 10'h200, 1'b0, 2'd1, "ofs2_s1");
    cyc(1'b0, 20'h0, 10'h048, 1'b0, 2'd2, "ofs_not_stored");

    // alignment
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "al_s3");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "al_s0");
    chk_err(1'b0, "al_clean");
    cyc(1'b1, 20'h0, 10'h200, 1'b0, 2'd1, "al_mis");
    chk_err(1'b1, "al_set");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "al_as_slot0");
    cyc(1'b0, 20'h0, 10'h200, 1'b0, 2'd1, "al_s1b");
    cyc(1'b0, 20'h0, 10'h048, 1'b0, 2'd2, "al_s2b");
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "al_aligned");
    chk_err(1'b1, "al_sticky");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "al_s0c");
    err_clr = 1'b1;
    cyc(1'b1, 20'h0, 10'h200, 1'b0, 2'd1, "al_set_clr");
    chk_err(1'b1, "al_set_wins");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "al_clr");
    chk_err(1'b0, "al_cleared");
    err_clr = 1'b0;
    cyc(1'b0, 20'h0, 10'h200, 1'b0, 2'd1, "al_s1d");
    cyc(1'b0, 20'h0, 10'h048, 1'b0, 2'd2, "al_s2d");

    // clock enable: frozen for 5 cycles while inputs churn
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "cen_s3");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "cen_s0");
    cen = 1'b0;
    err_clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pg_rst = i[0];
      cyc(~i[0], 20'(i * 32'h33333 + 32'h1), 10'h003, 1'b0, 2'd0, "cen_frozen");
      chk_err(1'b0, "cen_err_frozen");
    end
    cen = 1'b1;
    pg_rst = 1'b0;
    err_clr = 1'b0;
    cyc(1'b0, 20'h0, 10'h200, 1'b0, 2'd1, "cen_resume_s1");
    cyc(1'b0, 20'h0, 10'h048, 1'b0, 2'd2, "cen_resume_s2");
    cyc(1'b1, 20'h0, 10'h000, 1'b0, 2'd3, "cen_resume_s3");
    cyc(1'b0, 20'h0, 10'h003, 1'b0, 2'd0, "cen_resume_s0");
    chk_err(1'b0, "cen_resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jt51_pg_acc.md
# jt51_pg_acc

Parametrised, time-multiplexed phase accumulator bank for the operator pipeline. It holds one PW-bit phase per slot for SLOTS slots and adds a per-slot step each time that slot comes round. It supports per-slot preset-reset and hold, and applies an output phase offset. It reports accumulator wrap and slot alignment. It generalises the fixed 32-slot/20-bit phase accumulation stage so the same block can serve other slot counts and phase widths.

## Interface
Parameters:
- SLOTS, 32: number of time-multiplexed slots, ≥2, any integer.
- PW, 20: phase accumulator width.
- STEPW, 20: step input width, STEPW ≤ PW, zero-extended to PW.
- OW, 10: output phase width, OW ≤ PW.
- CW, $clog2(SLOTS): slot index width.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- cen  in  1  clock enable; no state changes while 0.
- zero  in  1  current inputs belong to slot 0.
- step  in  STEPW  phase increment for current slot.
- pg_rst  in  1  load preset into current slot.
- hold  in  1  freeze current slot's phase.
- preset  in  PW  value loaded by pg_rst.
- ofs  in  OW  output phase offset for current slot.
- err_clr  in  1  clear slot_err.
- phase_out  out  OW  offset phase of the output slot.
- wrap  out  1  accumulator carried out on the output slot's update.
- slot_out  out  CW  slot index of phase_out/wrap.
- slot_err  out  1  sticky misalignment flag.

## Operation
- Storage is SLOTS×PW registers, all cleared by reset. A slot counter cnt is reset to 0.
- Current slot index, each cen cycle: cur = zero ? 0 : cnt. Next counter: cnt ← (cur == SLOTS-1) ? 0 : cur+1.
- Misalignment: slot_err is set when zero=1 and cnt≠0. It clears on err_clr=1. If set and clear happen in the same cycle, set wins. Reset clears it.
- Stage A, on cen: old = mem[cur]. Then:
  - pg_rst=1: new = preset, c = 0. pg_rst has priority over hold.
  - else hold=1: new = old, c = 0.
  - else {c, new} = old + step, computed PW+1 bits wide, so new is modulo 2^PW.
- mem[cur] ← new in the same cycle. A slot recurs only after SLOTS ≥ 2 cycles, so there is no read/write hazard.
- Stage A registers: topA = new[PW-1:PW-OW], ofsA = ofs, wrapA = c, slotA = cur.
- Stage B, on cen:
  - phase_out ← topA + ofsA, modulo 2^OW.
  - wrap ← wrapA.
  - slot_out ← slotA.
- Offset is applied to the output only; it never enters the stored phase.

## Timing
- Latency: inputs sampled at cen-edge n appear on outputs after cen-edge n+1, i.e. 2 cen-qualified edges.
- Outputs, slot_out and slot_err are registered; no combinational input→output path.
- cen=0: counter, memory, both stages and slot_err hold. err_clr is ignored.
- Reset is asynchronous at any time, including mid-frame. While rst_n=0:
  - all outputs are 0, including phase_out, wrap, slot_out and slot_err;
  - the stage registers, memory and cnt are 0.
- After release: the first cen cycle processes slot 0 unless zero realigns it. The first valid output follows one cen later.
- zero asserted every SLOTS cycles at cnt=0: no effect beyond alignment, and slot_err stays 0.
- Phase wrap-around is silent modulo 2^PW and is signalled only by wrap. Offset overflow is silent modulo 2^OW.

## Test plan
Configuration for all scenarios: SLOTS=4, PW=20, STEPW=20, OW=10, cen=1 unless stated.
1. Reset: assert rst_n=0 mid-frame with nonzero phases → phase_out, wrap, slot_out, slot_err = 0 immediately. After release, slot 0 with step 0 → phase_out=0 for all slots.
2. Accumulate: slot 0 step=0x00400, others 0, zero on slot 0 → slot_out=0 outputs show phase_out 1, 2, 3 on successive frames. Other slots stay 0. Outputs arrive 2 cycles after inputs.
3. Wrap: slot 1 step=0x80000 → frame 1: phase_out=0x200, wrap=0. Frame 2: phase_out=0x000, wrap=1. Frame 3: 0x200, wrap=0.
4. Preset/hold/offset:
   - slot 2 with pg_rst=1, preset=0x12345 → phase_out=0x048.
   - Next frame, pg_rst=1 and hold=1 together → still 0x048 (preset reloaded).
   - Then hold=1, step=0x400 → stays 0x048.
   - Then ofs=0x3C0 with step 0 → 0x008 (modulo 1024).
5. Alignment: assert zero when cnt=2 → slot_err=1 and that input is processed as slot 0. Later zero at cnt=0 keeps slot_err=1. err_clr=1 in the same cycle as a new misaligned zero → slot_err stays 1. err_clr alone → 0.
6. Clock enable: drop cen for 5 cycles mid-frame while toggling step, pg_rst and zero → outputs and slot_err frozen. Sequence resumes exactly where stopped, with identical outputs to an uninterrupted run.
